// File: rtl/accumulator_requantizer.sv
// Requantizes Q parallel accumulator sums (bias add, rounded shift, saturate, optional ReLU)
// and streams the lanes out one word at a time with valid/ready handshaking.
module accumulator_requantizer #(
  parameter int Q         = 4,
  parameter int REG_DEPTH = 8,
  parameter int ACC_W     = 32,
  localparam int LW       = (Q > 1) ? $clog2(Q) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acc_valid,
  input  logic [Q-1:0][ACC_W-1:0]   acc_in,
  input  logic [Q-1:0][ACC_W-1:0]   bias_in,
  input  logic [4:0]                shift,
  input  logic                      relu_en,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_DEPTH-1:0]      out_data,
  output logic [LW-1:0]             out_lane,
  output logic                      out_last
);

  // Two guard bits: one for the bias add, one for the rounding addend.
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] MAX_OUT = SW'(2 ** (REG_DEPTH - 1) - 1);
  localparam logic signed [SW-1:0] MIN_OUT = SW'(-(2 ** (REG_DEPTH - 1)));
  localparam logic [LW-1:0]        LAST_LANE = LW'(Q - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, SEND} state_t;

  state_t                    state_reg, state_next;
  logic [Q-1:0][ACC_W-1:0]   acc_reg, bias_reg;
  logic [4:0]                shift_reg;
  logic                      relu_reg;
  logic [LW-1:0]             lane_reg;
  logic [REG_DEPTH-1:0]      result_reg [Q];
  logic [REG_DEPTH-1:0]      quant [Q];

  wire capture  = (state_reg == IDLE) && acc_valid;
  wire transfer = (state_reg == SEND) && out_ready;
  wire at_last  = (lane_reg == LAST_LANE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (acc_valid) state_next = COMPUTE;
      COMPUTE: state_next = SEND;
      SEND:    if (out_ready && at_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      lane_reg  <= '0;
      acc_reg   <= '0;
      bias_reg  <= '0;
      shift_reg <= '0;
      relu_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        acc_reg   <= acc_in;
        bias_reg  <= bias_in;
        shift_reg <= shift;
        relu_reg  <= relu_en;
      end
      if (state_reg == COMPUTE) begin
        lane_reg <= '0;
      end else if (transfer) begin
        lane_reg <= at_last ? '0 : lane_reg + LW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < Q; gi++) begin : g_lane
    logic signed [SW-1:0] sum, rnd, shifted, sat;

    always_comb begin
      sum     = SW'($signed(acc_reg[gi])) + SW'($signed(bias_reg[gi]));
      rnd     = (shift_reg == 5'd0) ? '0 : (SW'(1) << (shift_reg - 5'd1));
      shifted = (sum + rnd) >>> shift_reg;
      if (shifted > MAX_OUT)      sat = MAX_OUT;
      else if (shifted < MIN_OUT) sat = MIN_OUT;
      else                        sat = shifted;
      if (relu_reg && sat < 0)    sat = '0;
      quant[gi] = sat[REG_DEPTH-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        result_reg[gi] <= '0;
      end else if (state_reg == COMPUTE) begin
        result_reg[gi] <= quant[gi];
      end
    end
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    out_valid = (state_reg == SEND);
    out_data  = '0;
    out_lane  = '0;
    out_last  = 1'b0;
    if (state_reg == SEND) begin
      out_data = result_reg[lane_reg];
      out_lane = lane_reg;
      out_last = at_last;
    end
  end

endmodule
